// File: rtl/ifu_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ifu_fetch_pkg
// Description : Shared definitions for the instruction fetch unit: FSM state
//               encoding, the NOP word substituted on faulting fetches and
//               the default reset PC.
// Revision    : 1.0 - initial release
// ============================================================================
package ifu_fetch_pkg;

  // Fetch FSM states
  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,  // presenting a request to instruction memory
    ST_WAIT = 2'd1,  // request granted, waiting for the response
    ST_HOLD = 2'd2   // instruction held for decode
  } ifu_state_e;

  // addi x0, x0, 0 -- handed to decode in place of a faulting fetch word
  localparam logic [31:0] IFU_NOP      = 32'h0000_0013;

  // Default PC after reset
  localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;

endpackage : ifu_fetch_pkg
`default_nettype wire

// File: rtl/ifu_perf_cnt.sv
`default_nettype none
// ============================================================================
// Module      : ifu_perf_cnt
// Description : Free-running 64-bit performance counters for the fetch unit:
//               instructions delivered to decode and cycles spent waiting on
//               instruction memory. Both wrap at 2^64.
//               Instantiated by ifu_fetch only when IFU_PERF_CNT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module ifu_perf_cnt
  import ifu_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_inc,
  input  logic        wait_inc,
  output logic [63:0] perf_fetch_cnt,
  output logic [63:0] perf_wait_cnt
);

  // Count delivered instructions and memory-wait cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_cnt <= 64'd0;
      perf_wait_cnt  <= 64'd0;
    end else begin
      if (fetch_inc) perf_fetch_cnt <= perf_fetch_cnt + 64'd1;
      if (wait_inc)  perf_wait_cnt  <= perf_wait_cnt + 64'd1;
    end
  end

endmodule : ifu_perf_cnt
`default_nettype wire

// File: rtl/ifu_fetch.sv
`default_nettype none
// ============================================================================
// Module      : ifu_fetch
// Description : Single-outstanding, non-speculative instruction fetch unit.
//               Holds the PC, issues one imem read at a time and hands
//               {pc, inst, fault} to decode over valid/ready. A redirect is
//               accepted in any state; a request already granted when the
//               redirect arrives is marked stale and its response discarded.
//               Optional feature macro: IFU_PERF_CNT_EN adds the 64-bit
//               perf_fetch_cnt / perf_wait_cnt outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter int               XLEN     = 32,
  parameter int               INST_W   = 32,
  parameter logic [XLEN-1:0]  RESET_PC = XLEN'(IFU_RESET_PC)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [XLEN-1:0]   imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  input  logic              imem_rsp_err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [INST_W-1:0] out_inst,
  output logic              out_fault
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [63:0]       perf_fetch_cnt,
  output logic [63:0]       perf_wait_cnt
`endif
);

  ifu_state_e      state;
  logic [XLEN-1:0] pc;
  logic            drop;   // the outstanding request predates a redirect

  // The memory samples the address only on the handshake, so it can simply
  // track the PC register; a redirect in REQ retargets the pending request.
  assign imem_req_addr = pc;

  // Fetch FSM with registered handshake outputs; redirect has top priority
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_REQ;
      pc             <= RESET_PC;
      drop           <= 1'b0;
      imem_req_valid <= 1'b0;
      out_valid      <= 1'b0;
      out_pc         <= RESET_PC;
      out_inst       <= '0;
      out_fault      <= 1'b0;
    end else begin
      case (state)
        ST_REQ: begin
          // Raises the request on the first cycle out of reset as well
          imem_req_valid <= 1'b1;
          if (imem_req_valid && imem_req_ready) begin
            state          <= ST_WAIT;
            imem_req_valid <= 1'b0;
            // Granted address is about to become stale
            drop           <= redirect_valid;
          end
          if (redirect_valid) pc <= redirect_pc;
        end

        ST_WAIT: begin
          if (imem_rsp_valid) begin
            if (drop || redirect_valid) begin
              // Stale response: throw it away and refetch from the new PC
              drop           <= 1'b0;
              state          <= ST_REQ;
              imem_req_valid <= 1'b1;
            end else begin
              out_pc    <= pc;
              out_inst  <= imem_rsp_err ? INST_W'(IFU_NOP) : imem_rsp_data;
              out_fault <= imem_rsp_err;
              out_valid <= 1'b1;
              state     <= ST_HOLD;
            end
          end else if (redirect_valid) begin
            drop <= 1'b1;
          end
          if (redirect_valid) pc <= redirect_pc;
        end

        ST_HOLD: begin
          // A redirect alongside out_ready still consumes the instruction,
          // but the next fetch goes to the redirect target, not pc+4.
          if (redirect_valid) begin
            pc             <= redirect_pc;
            out_valid      <= 1'b0;
            imem_req_valid <= 1'b1;
            state          <= ST_REQ;
          end else if (out_ready) begin
            pc             <= pc + XLEN'(4);
            out_valid      <= 1'b0;
            imem_req_valid <= 1'b1;
            state          <= ST_REQ;
          end
        end

        default: begin
          state          <= ST_REQ;
          drop           <= 1'b0;
          imem_req_valid <= 1'b0;
          out_valid      <= 1'b0;
        end
      endcase
    end
  end

`ifdef IFU_PERF_CNT_EN
  ifu_perf_cnt u_perf_cnt (
    .clk            (clk),
    .rst            (rst),
    .fetch_inc      (out_valid & out_ready),
    .wait_inc       (state == ST_WAIT),
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_wait_cnt  (perf_wait_cnt)
  );
`endif

endmodule : ifu_fetch
`default_nettype wire
